dc_reload_sequencer: RTL and testbench

Sequences data-counter (DC) reloads from memory and drives the reload/mutate/data inputs of the DC value update logic (dc_reload, dc_mutate, mem_in). Accepts reload requests (DC index + memory address) from core control, buffers them in order, and issues one memory read at a time. Returns each word as a single-cycle reload strobe. Exports a per-DC busy mask so control stalls reads of a DC with a reload pending.

---
 rtl/dc_pkg.sv | 21 ++
 rtl/dc_req_fifo.sv | 68 ++++++
 rtl/dc_reload_sequencer.sv | 140 ++++++++++++++
 tb/tb_dc_reload_sequencer.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dc_pkg.sv
// Shared types for the data-counter reload sequencer: DC index, FSM encoding,
// and a one-hot decode used for the busy mask.
package dc_pkg;

    localparam int unsigned NUM_DC   = 4;
    localparam int unsigned DC_IDX_W = 2;

    typedef logic [DC_IDX_W-1:0] dc_idx_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        WRITE = 2'd3
    } dc_reload_state_t;

    function automatic logic [NUM_DC-1:0] dc_onehot(input dc_idx_t dc);
        dc_onehot = NUM_DC'(1) << dc;
    endfunction

endpackage

// File: rtl/dc_req_fifo.sv
// In-order request FIFO with an occupancy counter and a per-entry tag view,
// so the parent can see which queued entries are live and what they target.
module dc_req_fifo #(
    parameter int unsigned WIDTH = 34,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned TAG_W = 2
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          push,
    input  logic [WIDTH-1:0]              push_data,
    input  logic                          pop,
    output logic                          full,
    output logic                          empty,
    output logic [WIDTH-1:0]              head_data,
    output logic [DEPTH-1:0]              entry_valid,
    output logic [DEPTH-1:0][TAG_W-1:0]   entry_tag
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DEPTH-1:0][WIDTH-1:0] mem_q;
    logic [PTR_W-1:0]            wr_ptr_q;
    logic [PTR_W-1:0]            rd_ptr_q;
    logic [CNT_W-1:0]            count_q;
    logic                        do_push;
    logic                        do_pop;
    logic [PTR_W-1:0]            offs [DEPTH];

    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == '0);
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign head_data = mem_q[rd_ptr_q];

    // An entry is live when its distance from the read pointer is below the occupancy.
    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            offs[i]        = PTR_W'(i) - rd_ptr_q;
            entry_valid[i] = ({1'b0, offs[i]} < count_q);
            entry_tag[i]   = mem_q[i][WIDTH-1 -: TAG_W];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/dc_reload_sequencer.sv
// Queues DC reload requests, performs one memory read at a time, and returns
// each word to the DC update logic as a single-cycle reload strobe.
module dc_reload_sequencer
    import dc_pkg::*;
#(
    parameter int unsigned WORD_WIDTH = 32,
    parameter int unsigned DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [1:0]            req_dc,
    input  logic [WORD_WIDTH-1:0] req_addr,
    output logic                  mem_rd_valid,
    input  logic                  mem_rd_ready,
    output logic [WORD_WIDTH-1:0] mem_rd_addr,
    input  logic                  mem_resp_valid,
    input  logic [WORD_WIDTH-1:0] mem_resp_data,
    output logic                  dc_reload,
    output logic [1:0]            dc_mutate,
    output logic [WORD_WIDTH-1:0] mem_in,
    output logic [NUM_DC-1:0]     dc_busy,
    output logic                  idle
);

    localparam int unsigned ENTRY_W = DC_IDX_W + WORD_WIDTH;

    dc_reload_state_t                 state_q;
    dc_reload_state_t                 state_d;
    logic                             fifo_full;
    logic                             fifo_empty;
    logic                             fifo_push;
    logic                             fifo_pop;
    logic [ENTRY_W-1:0]               push_entry;
    logic [ENTRY_W-1:0]               head_entry;
    logic [DEPTH-1:0]                 entry_valid;
    logic [DEPTH-1:0][DC_IDX_W-1:0]   entry_tag;
    dc_idx_t                          head_dc;
    logic [WORD_WIDTH-1:0]            head_addr;
    dc_idx_t                          flight_dc_q;
    dc_idx_t                          flight_dc_d;
    dc_idx_t                          dc_mutate_d;
    logic [WORD_WIDTH-1:0]            mem_in_d;
    logic                             fifo_nonempty_next;

    assign push_entry = {req_dc, req_addr};
    assign fifo_push  = req_valid && !fifo_full;
    assign req_ready  = !fifo_full;
    assign head_dc    = head_entry[ENTRY_W-1 -: DC_IDX_W];
    assign head_addr  = head_entry[WORD_WIDTH-1:0];

    dc_req_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH),
        .TAG_W (DC_IDX_W)
    ) u_fifo (
        .clk         (clk),
        .reset_n     (reset_n),
        .push        (fifo_push),
        .push_data   (push_entry),
        .pop         (fifo_pop),
        .full        (fifo_full),
        .empty       (fifo_empty),
        .head_data   (head_entry),
        .entry_valid (entry_valid),
        .entry_tag   (entry_tag)
    );

    // Includes a push landing on this edge, so a new request reaches ISSUE next cycle.
    assign fifo_nonempty_next = !fifo_empty || fifo_push;

    always_comb begin
        state_d     = state_q;
        fifo_pop    = 1'b0;
        flight_dc_d = flight_dc_q;
        dc_mutate_d = dc_mutate;
        mem_in_d    = mem_in;
        case (state_q)
            IDLE: begin
                if (fifo_nonempty_next) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (mem_rd_ready) begin
                    fifo_pop    = 1'b1;
                    flight_dc_d = head_dc;
                    state_d     = WAIT;
                end
            end
            WAIT: begin
                if (mem_resp_valid) begin
                    mem_in_d    = mem_resp_data;
                    dc_mutate_d = flight_dc_q;
                    state_d     = WRITE;
                end
            end
            WRITE: begin
                state_d = fifo_nonempty_next ? ISSUE : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            flight_dc_q <= '0;
            dc_mutate   <= '0;
            mem_in      <= '0;
        end else begin
            state_q     <= state_d;
            flight_dc_q <= flight_dc_d;
            dc_mutate   <= dc_mutate_d;
            mem_in      <= mem_in_d;
        end
    end

    assign mem_rd_valid = (state_q == ISSUE);
    assign mem_rd_addr  = (state_q == ISSUE) ? head_addr : '0;
    assign dc_reload    = (state_q == WRITE);
    assign idle         = fifo_empty && (state_q == IDLE);

    // In ISSUE the head is still a live FIFO entry; the in-flight slot only counts after the pop.
    always_comb begin
        dc_busy = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (entry_valid[i]) begin
                dc_busy = dc_busy | dc_onehot(entry_tag[i]);
            end
        end
        if ((state_q == WAIT) || (state_q == WRITE)) begin
            dc_busy = dc_busy | dc_onehot(flight_dc_q);
        end
    end

endmodule

// File: tb/tb_dc_reload_sequencer.sv
// Bench for dc_reload_sequencer: directed scenarios plus randomized traffic
// checked against a queue/per-DC-count model of pending reloads.
module tb_dc_reload_sequencer;

    localparam int unsigned WW    = 32;
    localparam int unsigned DEPTH = 2;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          req_valid;
    logic          req_ready;
    logic [1:0]    req_dc;
    logic [WW-1:0] req_addr;
    logic          mem_rd_valid;
    logic          mem_rd_ready;
    logic [WW-1:0] mem_rd_addr;
    logic          mem_resp_valid;
    logic [WW-1:0] mem_resp_data;
    logic          dc_reload;
    logic [1:0]    dc_mutate;
    logic [WW-1:0] mem_in;
    logic [3:0]    dc_busy;
    logic          idle;

    int checks = 0;
    int errors = 0;

    dc_reload_sequencer #(.WORD_WIDTH(WW), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_dc         (req_dc),
        .req_addr       (req_addr),
        .mem_rd_valid   (mem_rd_valid),
        .mem_rd_ready   (mem_rd_ready),
        .mem_rd_addr    (mem_rd_addr),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .dc_reload      (dc_reload),
        .dc_mutate      (dc_mutate),
        .mem_in         (mem_in),
        .dc_busy        (dc_busy),
        .idle           (idle)
    );

    always #5 clk = ~clk;

    function automatic logic [WW-1:0] mem_word(input logic [WW-1:0] a);
        if (a == 32'h100) return 32'hDEADBEEF;
        return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    // Memory model: one outstanding read, configurable ready rate and response delay.
    int unsigned   ready_pct = 100;
    int unsigned   min_delay = 0;
    int unsigned   max_delay = 0;
    bit            spur_req = 1'b0;
    bit            pend = 1'b0;
    int unsigned   pend_delay = 0;
    logic [WW-1:0] pend_addr = '0;

    initial begin
        mem_rd_ready   = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        forever begin
            @(posedge clk); #1;
            mem_resp_valid = 1'b0;
            if (spur_req) begin
                mem_resp_valid = 1'b1;
                mem_resp_data  = 32'h5555AAAA;
                spur_req       = 1'b0;
            end else if (pend) begin
                if (pend_delay == 0) begin
                    mem_resp_valid = 1'b1;
                    mem_resp_data  = mem_word(pend_addr);
                    pend           = 1'b0;
                end else begin
                    pend_delay--;
                end
            end
            mem_rd_ready = !pend && ($urandom_range(99) < ready_pct);
            if (mem_rd_valid && mem_rd_ready) begin
                pend       = 1'b1;
                pend_delay = $urandom_range(max_delay, min_delay);
                pend_addr  = mem_rd_addr;
            end
        end
    end

    // Reference model: accepted requests form an ordered queue of expected reloads,
    // and a DC is busy while it has any accepted-but-not-yet-written reload.
    typedef struct packed {
        logic [1:0]    dc;
        logic [WW-1:0] data;
    } exp_t;

    exp_t       sb [$];
    int         outst [4];
    logic [3:0] mon_eb;
    exp_t       mon_e;

    always @(negedge clk) begin
        if (!reset_n) begin
            sb.delete();
            for (int i = 0; i < 4; i++) outst[i] = 0;
        end else begin
            mon_eb = '0;
            for (int i = 0; i < 4; i++) if (outst[i] > 0) mon_eb[i] = 1'b1;
            checks++;
            if (dc_busy !== mon_eb) begin
                errors++;
                $display("FAIL model_busy t=%0t got %b want %b", $time, dc_busy, mon_eb);
            end
            if (dc_reload === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL model_unexpected_reload t=%0t dc=%0d data=%h", $time, dc_mutate, mem_in);
                end else begin
                    mon_e = sb.pop_front();
                    if (dc_mutate !== mon_e.dc || mem_in !== mon_e.data) begin
                        errors++;
                        $display("FAIL model_reload t=%0t got dc=%0d data=%h want dc=%0d data=%h",
                                 $time, dc_mutate, mem_in, mon_e.dc, mon_e.data);
                    end
                    outst[mon_e.dc]--;
                end
            end
            if (req_valid === 1'b1 && req_ready === 1'b1) begin
                sb.push_back(exp_t'{dc: req_dc, data: mem_word(req_addr)});
                outst[req_dc]++;
            end
        end
    end

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (mem_rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got %b want 0", mem_rd_valid); end
        checks++; if (mem_rd_addr !== '0) begin errors++; $display("FAIL reset_rd_addr got %h want 0", mem_rd_addr); end
        checks++; if (dc_reload !== 1'b0) begin errors++; $display("FAIL reset_reload got %b want 0", dc_reload); end
        checks++; if (dc_mutate !== 2'd0) begin errors++; $display("FAIL reset_mutate got %0d want 0", dc_mutate); end
        checks++; if (mem_in !== '0) begin errors++; $display("FAIL reset_mem_in got %h want 0", mem_in); end
        checks++; if (dc_busy !== 4'b0) begin errors++; $display("FAIL reset_busy got %b want 0000", dc_busy); end
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL reset_idle got %b want 1", idle); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        ready_pct = 100; min_delay = 0; max_delay = 0;
        req_valid = 1'b1; req_dc = 2'd2; req_addr = 32'h100;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        checks++; if (mem_rd_valid !== 1'b1) begin errors++; $display("FAIL single_c1_rd_valid got %b want 1", mem_rd_valid); end
        checks++; if (mem_rd_addr !== 32'h100) begin errors++; $display("FAIL single_c1_rd_addr got %h want 00000100", mem_rd_addr); end
        checks++; if (dc_busy !== 4'b0100) begin errors++; $display("FAIL single_c1_busy got %b want 0100", dc_busy); end
        @(posedge clk); #1; @(negedge clk);
        checks++; if (dc_reload !== 1'b0) begin errors++; $display("FAIL single_c2_reload got %b want 0", dc_reload); end
        checks++; if (dc_busy !== 4'b0100) begin errors++; $display("FAIL single_c2_busy got %b want 0100", dc_busy); end
        @(posedge clk); #1; @(negedge clk);
        checks++; if (dc_reload !== 1'b1) begin errors++; $display("FAIL single_c3_reload got %b want 1", dc_reload); end
        checks++; if (dc_mutate !== 2'd2) begin errors++; $display("FAIL single_c3_mutate got %0d want 2", dc_mutate); end
        checks++; if (mem_in !== 32'hDEADBEEF) begin errors++; $display("FAIL single_c3_mem_in got %h want deadbeef", mem_in); end
        checks++; if (dc_busy !== 4'b0100) begin errors++; $display("FAIL single_c3_busy got %b want 0100", dc_busy); end
        @(posedge clk); #1; @(negedge clk);
        checks++; if (dc_reload !== 1'b0) begin errors++; $display("FAIL single_c4_reload got %b want 0", dc_reload); end
        checks++; if (dc_busy !== 4'b0000) begin errors++; $display("FAIL single_c4_busy got %b want 0000", dc_busy); end
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL single_c4_idle got %b want 1", idle); end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        bit            seen = 1'b0;
        logic [1:0]    got_dc = '0;
        logic [WW-1:0] got_data = '0;
        ready_pct = 0;
        req_valid = 1'b1; req_dc = 2'd3; req_addr = 32'h2000;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            checks++; if (mem_rd_valid !== 1'b1) begin errors++; $display("FAIL bp_rd_valid c%0d got %b want 1", c, mem_rd_valid); end
            checks++; if (mem_rd_addr !== 32'h2000) begin errors++; $display("FAIL bp_rd_addr c%0d got %h want 00002000", c, mem_rd_addr); end
            checks++; if (dc_reload !== 1'b0) begin errors++; $display("FAIL bp_reload c%0d got %b want 0", c, dc_reload); end
            @(posedge clk); #1;
        end
        ready_pct = 100;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (dc_reload === 1'b1) begin seen = 1'b1; got_dc = dc_mutate; got_data = mem_in; end
            @(posedge clk); #1;
        end
        checks++; if (!seen) begin errors++; $display("FAIL bp_timeout got no reload want one"); end
        checks++; if (got_dc !== 2'd3) begin errors++; $display("FAIL bp_mutate got %0d want 3", got_dc); end
        checks++; if (got_data !== mem_word(32'h2000)) begin errors++; $display("FAIL bp_data got %h want %h", got_data, mem_word(32'h2000)); end
        @(posedge clk); #1;
    endtask

    task automatic test_full();
        logic [1:0]    want_dc [3];
        logic [WW-1:0] want_addr [3];
        logic [1:0]    rl_dc [3];
        logic [WW-1:0] rl_data [3];
        int            got = 0;
        bit            acc = 1'b0;
        bit            acc_next = 1'b0;
        want_dc[0] = 2'd0; want_addr[0] = 32'h300;
        want_dc[1] = 2'd1; want_addr[1] = 32'h304;
        want_dc[2] = 2'd3; want_addr[2] = 32'h308;
        ready_pct = 0;
        req_valid = 1'b1; req_dc = want_dc[0]; req_addr = want_addr[0];
        @(posedge clk); #1;
        req_dc = want_dc[1]; req_addr = want_addr[1];
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL full_ready_one got %b want 1", req_ready); end
        @(posedge clk); #1;
        req_dc = want_dc[2]; req_addr = want_addr[2];
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL full_ready_zero c%0d got %b want 0", c, req_ready); end
            checks++; if (dc_busy !== 4'b0011) begin errors++; $display("FAIL full_busy_two c%0d got %b want 0011", c, dc_busy); end
            @(posedge clk); #1;
        end
        ready_pct = 100;
        for (int c = 0; c < 40 && got < 3; c++) begin
            @(negedge clk);
            if (acc_next) begin
                acc_next = 1'b0;
                checks++; if (dc_busy !== 4'b1011) begin errors++; $display("FAIL full_busy_three got %b want 1011", dc_busy); end
            end
            if (!acc && req_ready === 1'b1) begin acc = 1'b1; acc_next = 1'b1; end
            if (dc_reload === 1'b1) begin rl_dc[got] = dc_mutate; rl_data[got] = mem_in; got++; end
            @(posedge clk); #1;
            if (acc) req_valid = 1'b0;
        end
        req_valid = 1'b0;
        checks++; if (!acc) begin errors++; $display("FAIL full_third_accept got none want accepted"); end
        checks++; if (got != 3) begin errors++; $display("FAIL full_reload_count got %0d want 3", got); end
        for (int i = 0; i < got; i++) begin
            checks++;
            if (rl_dc[i] !== want_dc[i] || rl_data[i] !== mem_word(want_addr[i])) begin
                errors++;
                $display("FAIL full_order[%0d] got dc=%0d data=%h want dc=%0d data=%h",
                         i, rl_dc[i], rl_data[i], want_dc[i], mem_word(want_addr[i]));
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_dup();
        logic [WW-1:0] rl_data [2];
        int            got = 0;
        bit            drop = 1'b0;
        ready_pct = 100; min_delay = 0; max_delay = 0;
        req_valid = 1'b1; req_dc = 2'd1; req_addr = 32'h10;
        @(posedge clk); #1;
        req_addr = 32'h20;
        for (int c = 0; c < 30 && got < 2; c++) begin
            @(negedge clk);
            if (dc_busy[1] !== 1'b1) drop = 1'b1;
            if (dc_reload === 1'b1) begin rl_data[got] = mem_in; got++; end
            @(posedge clk); #1;
            req_valid = 1'b0;
        end
        @(negedge clk);
        checks++; if (got != 2) begin errors++; $display("FAIL dup_count got %0d want 2", got); end
        checks++; if (got > 0 && rl_data[0] !== mem_word(32'h10)) begin errors++; $display("FAIL dup_first got %h want %h", rl_data[0], mem_word(32'h10)); end
        checks++; if (got > 1 && rl_data[1] !== mem_word(32'h20)) begin errors++; $display("FAIL dup_second got %h want %h", rl_data[1], mem_word(32'h20)); end
        checks++; if (drop) begin errors++; $display("FAIL dup_busy_hold got dropped want held"); end
        checks++; if (dc_busy !== 4'b0000) begin errors++; $display("FAIL dup_busy_after got %b want 0000", dc_busy); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        bit bad_reload = 1'b0;
        bit bad_idle = 1'b0;
        bit bad_rd = 1'b0;
        ready_pct = 100; min_delay = 10; max_delay = 10;
        req_valid = 1'b1; req_dc = 2'd2; req_addr = 32'h400;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        reset_n = 1'b0;
        #2;
        checks++; if (mem_in !== '0) begin errors++; $display("FAIL rstmid_mem_in got %h want 0", mem_in); end
        checks++; if (dc_mutate !== 2'd0) begin errors++; $display("FAIL rstmid_mutate got %0d want 0", dc_mutate); end
        checks++; if (dc_busy !== 4'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0000", dc_busy); end
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL rstmid_idle got %b want 1", idle); end
        checks++; if (mem_rd_valid !== 1'b0) begin errors++; $display("FAIL rstmid_rd_valid got %b want 0", mem_rd_valid); end
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (dc_reload !== 1'b0) bad_reload = 1'b1;
            if (idle !== 1'b1) bad_idle = 1'b1;
            if (mem_rd_valid !== 1'b0) bad_rd = 1'b1;
            @(posedge clk); #1;
        end
        checks++; if (bad_reload) begin errors++; $display("FAIL rstmid_late_reload got pulse want none"); end
        checks++; if (bad_idle) begin errors++; $display("FAIL rstmid_late_idle got 0 want 1"); end
        checks++; if (bad_rd) begin errors++; $display("FAIL rstmid_late_rd got 1 want 0"); end
        min_delay = 0; max_delay = 0;
    endtask

    task automatic test_spurious();
        bit bad_reload = 1'b0;
        bit bad_idle = 1'b0;
        bit bad_mem_in = 1'b0;
        ready_pct = 0;
        spur_req = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (dc_reload !== 1'b0) bad_reload = 1'b1;
            if (idle !== 1'b1 || mem_rd_valid !== 1'b0) bad_idle = 1'b1;
            if (mem_in !== '0) bad_mem_in = 1'b1;
            @(posedge clk); #1;
        end
        checks++; if (bad_reload) begin errors++; $display("FAIL spur_reload got pulse want none"); end
        checks++; if (bad_idle) begin errors++; $display("FAIL spur_state got active want idle"); end
        checks++; if (bad_mem_in) begin errors++; $display("FAIL spur_mem_in got changed want 0"); end
    endtask

    task automatic test_random();
        bit done = 1'b0;
        ready_pct = 70; min_delay = 0; max_delay = 3;
        for (int c = 0; c < 400; c++) begin
            req_valid = ($urandom_range(1) == 1);
            req_dc    = 2'($urandom_range(3));
            req_addr  = $urandom;
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        for (int c = 0; c < 300 && !done; c++) begin
            @(negedge clk);
            if (idle === 1'b1 && sb.size() == 0) done = 1'b1;
            @(posedge clk); #1;
        end
        checks++; if (!done) begin errors++; $display("FAIL rand_drain got pending=%0d idle=%b want drained", sb.size(), idle); end
        @(negedge clk);
        checks++; if (dc_busy !== 4'b0) begin errors++; $display("FAIL rand_busy_final got %b want 0000", dc_busy); end
        @(posedge clk); #1;
    endtask

    initial begin
        req_valid = 1'b0;
        req_dc    = '0;
        req_addr  = '0;
        test_reset();
        test_single();
        test_backpressure();
        test_full();
        test_dup();
        test_reset_mid();
        test_spurious();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
